incdec_counter_bank: RTL
========================

# incdec_counter_bank

- Register array of DEPTH counters, each WIDTH bits, driven by a valid/ready command stream.
- Each command applies one of load, pre-increment, post-increment, pre-decrement, post-decrement, read or clear-all to one entry.
- Every command returns a one-entry registered response carrying the value that the matching ++/--/read expression yields.
- This is the stateful stage upstream of the combinational inc/dec expression blocks: it holds the array and pointer state whose snapshots those blocks consume. It also provides a clocked reference model for `array[idx++]++` semantics.

## Interface
Parameters:
- WIDTH, 8, counter width in bits
- DEPTH, 4, number of counters; must be a power of two, at least 2
- IDXW, $clog2(DEPTH), index width (derived)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when valid&&ready
- cmd_op  input  3  0 LOAD, 1 PRE_INC, 2 POST_INC, 3 PRE_DEC, 4 POST_DEC, 5 READ, 6 CLEAR_ALL, 7 illegal
- cmd_idx  input  IDXW  target entry when cmd_auto=0
- cmd_auto  input  1  target the internal pointer, then post-increment the pointer
- cmd_data  input  WIDTH  LOAD value
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when valid&&ready
- rsp_data  output  WIDTH  result value
- rsp_idx  output  IDXW  entry actually addressed
- rsp_err  output  1  illegal op
- rsp_sat  output  1  saturation occurred (see Configuration)
- ptr_out  output  IDXW  current auto pointer
- busy  output  1  CLEAR_ALL sweep in progress

## Operation
- FSM states: IDLE, CLEAR.
- IDLE:
  - cmd_ready = !rsp_valid || rsp_ready.
  - On accept, effective index is e = cmd_auto ? ptr : cmd_idx. Entry e is updated at the same edge and the response register is loaded.
- Result per op:
  - LOAD: mem[e]=cmd_data; rsp_data=cmd_data.
  - PRE_INC: mem[e]+1, returns the new value.
  - POST_INC: mem[e]+1, returns the old value.
  - PRE_DEC: mem[e]-1, returns the new value.
  - POST_DEC: mem[e]-1, returns the old value.
  - READ: returns mem[e]; no change.
  - Illegal (7): no array change; rsp_err=1, rsp_data=0.
- Auto pointer: when cmd_auto=1, ptr increments by 1 after use, wrapping modulo DEPTH. Any op, including READ, LOAD and illegal, advances it. cmd_auto=0 leaves ptr unchanged.
- CLEAR_ALL:
  - Enter CLEAR; busy=1, cmd_ready=0.
  - Zero one entry per cycle, index 0..DEPTH-1. ptr resets to 0 on the last cycle.
  - Return to IDLE, and only then issue the response: rsp_data=DEPTH, rsp_idx=0.
- Arithmetic is modulo 2^WIDTH by default: 8'hFF+1=8'h00 and 8'h00-1=8'hFF.
- Back-to-back commands to the same entry see the previous update. There is no read-before-write hazard: the array is flop-based and the next command reads the updated contents.

## Timing
- Reset values:
  - mem all 0, ptr 0, state IDLE.
  - rsp_valid, rsp_data, rsp_idx, rsp_err, rsp_sat all 0.
  - busy 0. cmd_ready 1 once out of reset.
- Latency:
  - Non-clear op: response appears the cycle after accept.
  - CLEAR_ALL: response appears DEPTH+1 cycles after accept.
- Throughput: one command per cycle while rsp_ready=1.
- Response stall: rsp_valid=1 with rsp_ready=0 holds all rsp_* stable and deasserts cmd_ready.
- Simultaneous accept and response pop in the same cycle: the new response replaces the old one with no bubble.
- Reset mid-sweep: everything returns to reset values immediately. The partially cleared array is zeroed by reset anyway.

## Configuration
- Macro: INCDEC_SATURATE_EN.
- Defined:
  - Increment of all-ones holds at all-ones; decrement of 0 holds at 0.
  - rsp_sat=1 on the clamped response, for both pre- and post- forms. A post form returns the old value with sat=1.
- Undefined:
  - Modulo wrap applies.
  - rsp_sat is tied 0.

## Test plan
- LOAD idx2=8'h10; PRE_INC idx2; POST_INC idx2; READ idx2 -> rsp_data 8'h10, 8'h11, 8'h11, 8'h12.
- LOAD idx1=8'hFF; POST_INC idx1; READ idx1:
  - without macro -> rsp_data 8'hFF, sat=0, then 8'h00.
  - with macro -> rsp_data 8'hFF, sat=1, then 8'hFF.
- Four POST_DEC commands with cmd_auto=1 from reset -> rsp_idx 0,1,2,3, rsp_data 0 each; ptr_out wraps to 0; READs return 8'hFF in all entries (no macro).
- Hold rsp_ready=0 for 3 cycles after a PRE_DEC -> cmd_ready=0 and rsp_* stable; release -> next queued command is accepted that cycle.
- Load entries with 1..4, then CLEAR_ALL -> busy=1 for 4 cycles, cmd_ready=0, response rsp_data=4; all READs return 0; ptr_out=0.
- Illegal op 7 with cmd_auto=1 -> rsp_err=1, array unchanged, ptr advances by 1. Assert rst_n low during a CLEAR sweep -> busy=0 and all outputs at reset values.

Source files
------------

// File: rtl/incdec_counter_bank_if.sv
// -----------------------------------------------------------------------------
// incdec_counter_bank_if
//   Command / response bundle for incdec_counter_bank.
//   master : issues commands (cmd_*) and consumes responses (rsp_ready)
//   slave  : the counter bank; accepts commands and presents responses
//   Signals:
//     cmd_valid/cmd_ready  command handshake
//     cmd_op[2:0]          operation code
//     cmd_idx[IDXW-1:0]    explicit target entry
//     cmd_auto             use and post-increment the internal pointer
//     cmd_data[WIDTH-1:0]  LOAD value
//     rsp_valid/rsp_ready  response handshake
//     rsp_data, rsp_idx    result value and entry addressed
//     rsp_err, rsp_sat     illegal op / saturation flags
// -----------------------------------------------------------------------------
interface incdec_counter_bank_if #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [IDXW-1:0]  cmd_idx;
    logic             cmd_auto;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [IDXW-1:0]  rsp_idx;
    logic             rsp_err;
    logic             rsp_sat;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_auto, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_idx, rsp_err, rsp_sat
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_auto, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_idx, rsp_err, rsp_sat
    );
endinterface

// File: rtl/incdec_counter_bank.sv
// -----------------------------------------------------------------------------
// incdec_counter_bank
//   Bank of DEPTH counters (WIDTH bits each) driven by a valid/ready command
//   stream. Each command (load, pre/post inc, pre/post dec, read, clear-all)
//   returns one registered response holding the value the corresponding
//   C-style ++/-- or read expression would yield.
//
//   Optional feature macro: INCDEC_SATURATE_EN
//     defined   : increments clamp at all-ones, decrements clamp at zero,
//                 rsp_sat flags the clamped response
//     undefined : modulo 2^WIDTH wrap, rsp_sat always 0
//
//   Ports:
//     clk      clock
//     rst_n    asynchronous active-low reset
//     bus      command/response interface (slave side)
//     ptr_out  current auto pointer
//     busy     CLEAR_ALL sweep in progress
// -----------------------------------------------------------------------------
module incdec_counter_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    incdec_counter_bank_if.slave bus,
    output logic [IDXW-1:0]      ptr_out,
    output logic                 busy
);

    localparam logic [2:0] OP_LOAD     = 3'd0;
    localparam logic [2:0] OP_PRE_INC  = 3'd1;
    localparam logic [2:0] OP_POST_INC = 3'd2;
    localparam logic [2:0] OP_PRE_DEC  = 3'd3;
    localparam logic [2:0] OP_POST_DEC = 3'd4;
    localparam logic [2:0] OP_READ     = 3'd5;
    localparam logic [2:0] OP_CLEAR    = 3'd6;

    localparam logic [WIDTH-1:0] CLEAR_RSP = WIDTH'(DEPTH);
    localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(DEPTH - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    // Returns {sat, next_value}.
    function automatic logic [WIDTH:0] inc_fn(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        n = v + 1'b1;
`ifdef INCDEC_SATURATE_EN
        if (&v) return {1'b1, v};
`endif
        return {1'b0, n};
    endfunction

    function automatic logic [WIDTH:0] dec_fn(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        n = v - 1'b1;
`ifdef INCDEC_SATURATE_EN
        if (v == '0) return {1'b1, v};
`endif
        return {1'b0, n};
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state, state_nxt;
    logic [IDXW-1:0]  ptr;
    logic [IDXW-1:0]  clr_idx;
    logic             clr_last;

    logic             rsp_valid_q, rsp_err_q, rsp_sat_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [IDXW-1:0]  rsp_idx_q;

    logic             cmd_ready_int;
    logic             accept;
    logic [IDXW-1:0]  eff_idx;
    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   inc_r, dec_r;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] res_data;
    logic             res_err, res_sat;

    assign eff_idx  = bus.cmd_auto ? ptr : bus.cmd_idx;
    assign cur      = mem[eff_idx];
    assign inc_r    = inc_fn(cur);
    assign dec_r    = dec_fn(cur);
    assign clr_last = (clr_idx == LAST_IDX);
    assign accept   = bus.cmd_valid && cmd_ready_int;

    // FSM next state and control outputs
    always_comb begin
        state_nxt     = state;
        cmd_ready_int = 1'b0;
        busy          = 1'b0;
        unique case (state)
            S_IDLE: begin
                cmd_ready_int = !rsp_valid_q || bus.rsp_ready;
                if (bus.cmd_valid && cmd_ready_int && bus.cmd_op == OP_CLEAR)
                    state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                busy = 1'b1;
                if (clr_last) state_nxt = S_IDLE;
            end
        endcase
    end

    // Per-op result and write-back value
    always_comb begin
        wr_en    = 1'b0;
        wr_data  = cur;
        res_data = '0;
        res_err  = 1'b0;
        res_sat  = 1'b0;
        case (bus.cmd_op)
            OP_LOAD: begin
                wr_en    = 1'b1;
                wr_data  = bus.cmd_data;
                res_data = bus.cmd_data;
            end
            OP_PRE_INC: begin
                wr_en    = 1'b1;
                wr_data  = inc_r[WIDTH-1:0];
                res_data = inc_r[WIDTH-1:0];
                res_sat  = inc_r[WIDTH];
            end
            OP_POST_INC: begin
                wr_en    = 1'b1;
                wr_data  = inc_r[WIDTH-1:0];
                res_data = cur;
                res_sat  = inc_r[WIDTH];
            end
            OP_PRE_DEC: begin
                wr_en    = 1'b1;
                wr_data  = dec_r[WIDTH-1:0];
                res_data = dec_r[WIDTH-1:0];
                res_sat  = dec_r[WIDTH];
            end
            OP_POST_DEC: begin
                wr_en    = 1'b1;
                wr_data  = dec_r[WIDTH-1:0];
                res_data = cur;
                res_sat  = dec_r[WIDTH];
            end
            OP_READ:  res_data = cur;
            OP_CLEAR: res_data = '0;
            default:  res_err  = 1'b1;
        endcase
    end

    // Control state, pointer and response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            clr_idx     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_idx_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_sat_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (bus.cmd_auto) ptr <= ptr + 1'b1;
                        if (bus.cmd_op == OP_CLEAR) begin
                            // Old response was popped this edge (accept
                            // implies rsp_ready or empty); hold off the new
                            // one until the sweep finishes.
                            clr_idx     <= '0;
                            rsp_valid_q <= 1'b0;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= res_data;
                            rsp_idx_q   <= eff_idx;
                            rsp_err_q   <= res_err;
                            rsp_sat_q   <= res_sat;
                        end
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_last) begin
                        ptr         <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= CLEAR_RSP;
                        rsp_idx_q   <= '0;
                        rsp_err_q   <= 1'b0;
                        rsp_sat_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Counter array: one entry zeroed per sweep cycle, else command write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == S_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (accept && wr_en) begin
            mem[eff_idx] <= wr_data;
        end
    end

    assign bus.cmd_ready = cmd_ready_int;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_sat   = rsp_sat_q;
    assign ptr_out       = ptr;

endmodule
